// File: rtl/sid_pipe_sched.sv
// Sample-run scheduler for dual-SID voice/filter pipelines; define SID_SCHED_SID2_EN
// to sequence the second SID, otherwise only SID0 is issued and filtered.
module sid_pipe_sched #(
  parameter int FLT_STAGES = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ovr_clr,
  output logic       voice_issue,
  output logic       voice_sid,
  output logic [1:0] voice_idx,
  output logic       voice_cap,
  output logic       cap_sid,
  output logic [1:0] cap_idx,
  output logic       filter_load,
  output logic       filter_sid,
  output logic [2:0] filter_stage,
  output logic       filter_done,
  output logic       audio_valid,
  output logic       busy,
  output logic       overrun
);

`ifdef SID_SCHED_SID2_EN
  localparam int NSID = 2;
`else
  localparam int NSID = 1;
`endif
  localparam int NV    = 3 * NSID;
  localparam int LOAD1 = 7 + FLT_STAGES;
  localparam int LAST  = 7 + FLT_STAGES + (NSID - 1) * (2 + FLT_STAGES);
  localparam int CW    = $clog2(LAST + 1);

  typedef enum logic [1:0] {IDLE, VOICE, FILT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick, tick_nxt;

  // tick counts cycles since the accepted start: cycle T+k holds tick == k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tick  <= '0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = VOICE;
          tick_nxt  = CW'(1);
        end
      end
      VOICE: begin
        tick_nxt = tick + CW'(1);
        if (int'(tick) == NV) state_nxt = FILT;
      end
      FILT: begin
        tick_nxt = tick + CW'(1);
        if (int'(tick) == LAST - 1) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next tick and registered, so nothing is combinational to ports
  int         n;
  logic       issue_d, vsid_d, cap_d, csid_d, load_d, fsid_d, done_d, audio_d, busy_d;
  logic [1:0] vidx_d, cidx_d;
  logic [2:0] stage_d;

  always_comb begin
    n       = int'(tick_nxt);
    issue_d = (n >= 1) && (n <= NV);
    vsid_d  = (NSID == 2) && issue_d && (n >= 4);
    vidx_d  = issue_d ? 2'((n - 1) % 3) : 2'd0;
    cap_d   = (n >= 2) && (n <= NV + 1);
    csid_d  = (NSID == 2) && cap_d && (n >= 5);
    cidx_d  = cap_d ? 2'((n - 2) % 3) : 2'd0;
    load_d  = (n == 5) || ((NSID == 2) && (n == LOAD1));
    fsid_d  = filter_sid;
    if (n == 5) fsid_d = 1'b0;
    else if ((NSID == 2) && (n == LOAD1)) fsid_d = 1'b1;
    stage_d = 3'd0;
    if ((n >= 6) && (n <= 5 + FLT_STAGES)) stage_d = 3'(n - 5);
    else if ((NSID == 2) && (n > LOAD1) && (n <= LOAD1 + FLT_STAGES)) stage_d = 3'(n - LOAD1);
    done_d  = (n == 6 + FLT_STAGES) || ((NSID == 2) && (n == LOAD1 + 1 + FLT_STAGES));
    audio_d = (n == LAST);
    busy_d  = (n != 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_issue  <= 1'b0;
      voice_sid    <= 1'b0;
      voice_idx    <= 2'd0;
      voice_cap    <= 1'b0;
      cap_sid      <= 1'b0;
      cap_idx      <= 2'd0;
      filter_load  <= 1'b0;
      filter_sid   <= 1'b0;
      filter_stage <= 3'd0;
      filter_done  <= 1'b0;
      audio_valid  <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      voice_issue  <= issue_d;
      voice_sid    <= vsid_d;
      voice_idx    <= vidx_d;
      voice_cap    <= cap_d;
      cap_sid      <= csid_d;
      cap_idx      <= cidx_d;
      filter_load  <= load_d;
      filter_sid   <= fsid_d;
      filter_stage <= stage_d;
      filter_done  <= done_d;
      audio_valid  <= audio_d;
      busy         <= busy_d;
      // A rejected start outranks a simultaneous clear
      if (start && busy) overrun <= 1'b1;
      else if (ovr_clr)  overrun <= 1'b0;
    end
  end

endmodule
